game_tick_gen: RTL and testbench

Parametrised game-tick generator and successor to the fixed four-speed game clock. It divides the system clock into a game tick whose period is set by a difficulty level. The period is computed arithmetically from parameters, so there is no fixed table. It adds pause without losing count progress, a single-cycle tick strobe, a tick counter, and optional automatic level-up every N ticks. It drives the game-logic update enable, and its `out_clk` output replaces the legacy toggling clock.

---
 rtl/game_tick_gen.sv | 127 ++++++++++++
 tb/tb_game_tick_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_gen.sv
// game_tick_gen
// ---------------------------------------------------------------------------
// Purpose:
//   Divides in_clk down to a game tick. The tick period depends on a
//   difficulty level and is computed arithmetically from the parameters:
//       P(l) = BASE_PERIOD - l*PERIOD_STEP, clamped to at least MIN_PERIOD.
//   Supports pause without losing progress, a one-cycle tick strobe, a
//   free-running tick counter and optional automatic level-up every
//   ACCEL_TICKS ticks.
//
// Ports:
//   in_clk      in   system clock, all logic on its rising edge
//   rst_n       in   synchronous active-low reset
//   run         in   1 = generate ticks, 0 = idle and load speed_sel
//   pause       in   1 = freeze all state while running
//   accel_en    in   enables automatic level-up
//   speed_sel   in   starting level, loaded while run is low
//   tick        out  one-cycle strobe per game tick
//   out_clk     out  toggles on every tick
//   level       out  level currently in effect
//   tick_count  out  ticks since reset, wrapping
// ---------------------------------------------------------------------------
module game_tick_gen #(
    parameter int CNT_W       = 32,
    parameter int LVL_W       = 3,
    parameter int TCNT_W      = 16,
    parameter int BASE_PERIOD = 25_000_000,
    parameter int PERIOD_STEP = 5_000_000,
    parameter int MIN_PERIOD  = 2_000_000,
    parameter int MAX_LEVEL   = 2**LVL_W - 1,
    parameter int ACCEL_TICKS = 16
) (
    input  logic              in_clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              pause,
    input  logic              accel_en,
    input  logic [LVL_W-1:0]  speed_sel,
    output logic              tick,
    output logic              out_clk,
    output logic [LVL_W-1:0]  level,
    output logic [TCNT_W-1:0] tick_count
);

    // The level*step product is formed in CNT_W+LVL_W bits so it cannot
    // overflow before it is compared against the available headroom.
    localparam int PW = CNT_W + LVL_W;

    localparam logic [PW-1:0] BASE_W = PW'(BASE_PERIOD);
    localparam logic [PW-1:0] STEP_W = PW'(PERIOD_STEP);
    localparam logic [PW-1:0] MIN_W  = PW'(MIN_PERIOD);

    // When the base period does not exceed the floor every level runs at the
    // floor; otherwise the headroom is how far the period may shrink.
    localparam bit            ALWAYS_MIN = (BASE_PERIOD <= MIN_PERIOD);
    localparam logic [PW-1:0] HEADROOM   =
        ALWAYS_MIN ? '0 : PW'(BASE_PERIOD - MIN_PERIOD);

    localparam logic [LVL_W-1:0] MAX_L = LVL_W'(MAX_LEVEL);

    localparam int              AW       = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [AW-1:0]   ACC_LAST = AW'(ACCEL_TICKS - 1);

    logic [CNT_W-1:0] counter;
    logic [AW-1:0]    accel_cnt;
    logic [LVL_W-1:0] start_level;
    logic [LVL_W-1:0] next_level;
    logic             accel_wrap;

    // Reload value for the down-counter at a given level: P(l) - 1.
    // The clamp test happens before the subtraction, so it never wraps.
    function automatic logic [CNT_W-1:0] reload_of(input logic [LVL_W-1:0] l);
        logic [PW-1:0] prod;
        logic [PW-1:0] p;
        prod = PW'(l) * STEP_W;
        if (ALWAYS_MIN || (prod > HEADROOM))
            p = MIN_W;
        else
            p = BASE_W - prod;
        return CNT_W'(p - PW'(1));
    endfunction

    // Level used when leaving idle, and the level after a tick event
    // (one step up when the accel counter completes, saturating at MAX_L).
    always_comb begin
        start_level = (speed_sel > MAX_L) ? MAX_L : speed_sel;
        accel_wrap  = accel_en && (accel_cnt == ACC_LAST);
        next_level  = level;
        if (accel_wrap && (level < MAX_L))
            next_level = level + 1'b1;
    end

    // Main sequencer. Priority: reset, then idle/load, then pause, then count.
    // The reload on a tick uses next_level so a level-up shortens the very
    // next interval.
    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            counter    <= '0;
            level      <= '0;
            accel_cnt  <= '0;
            tick       <= 1'b0;
            out_clk    <= 1'b0;
            tick_count <= '0;
        end else if (!run) begin
            level     <= start_level;
            counter   <= reload_of(start_level);
            accel_cnt <= '0;
            tick      <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (counter != '0) begin
            counter <= counter - 1'b1;
            tick    <= 1'b0;
        end else begin
            tick       <= 1'b1;
            out_clk    <= ~out_clk;
            tick_count <= tick_count + 1'b1;
            level      <= next_level;
            counter    <= reload_of(next_level);
            if (accel_wrap)
                accel_cnt <= '0;
            else if (accel_en)
                accel_cnt <= accel_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen
// ---------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for game_tick_gen with small parameters
//   (base 10, step 2, floor 3, accel every 2 ticks). A behavioural model
//   tracks the cycles left in the current interval with plain integers and
//   is compared against the DUT on every falling edge; directed sequences
//   add hand-computed interval lengths and output values.
// ---------------------------------------------------------------------------
module tb_game_tick_gen;

    localparam int CNT_W       = 8;
    localparam int LVL_W       = 3;
    localparam int TCNT_W      = 8;
    localparam int BASE_PERIOD = 10;
    localparam int PERIOD_STEP = 2;
    localparam int MIN_PERIOD  = 3;
    localparam int MAX_LEVEL   = 7;
    localparam int ACCEL_TICKS = 2;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              pause;
    logic              accel_en;
    logic [LVL_W-1:0]  speed_sel;
    logic              tick;
    logic              out_clk;
    logic [LVL_W-1:0]  level;
    logic [TCNT_W-1:0] tick_count;

    int total_checks;
    int bad_checks;
    bit check_en;

    // Model state
    int m_remaining;
    int m_level;
    int m_acc;
    int m_tick;
    int m_out_clk;
    int m_tick_count;

    game_tick_gen #(
        .CNT_W      (CNT_W),
        .LVL_W      (LVL_W),
        .TCNT_W     (TCNT_W),
        .BASE_PERIOD(BASE_PERIOD),
        .PERIOD_STEP(PERIOD_STEP),
        .MIN_PERIOD (MIN_PERIOD),
        .MAX_LEVEL  (MAX_LEVEL),
        .ACCEL_TICKS(ACCEL_TICKS)
    ) dut (
        .in_clk    (clk),
        .rst_n     (rst_n),
        .run       (run),
        .pause     (pause),
        .accel_en  (accel_en),
        .speed_sel (speed_sel),
        .tick      (tick),
        .out_clk   (out_clk),
        .level     (level),
        .tick_count(tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Period in cycles for a level, straight from the period rule.
    function automatic int period(input int l);
        if (l * PERIOD_STEP > BASE_PERIOD - MIN_PERIOD)
            return MIN_PERIOD;
        return BASE_PERIOD - l * PERIOD_STEP;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ru, input logic p,
                                 input logic a, input int sel);
        rst_n     = r;
        run       = ru;
        pause     = p;
        accel_en  = a;
        speed_sel = LVL_W'(sel);
    endtask

    // Counts falling edges until tick is seen; -1 when the budget expires.
    task automatic waitTick(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (tick) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Behavioural model: m_remaining is the number of counting cycles until
    // the next tick. Reset leaves the interval already expired.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_remaining  = 1;
            m_level      = 0;
            m_acc        = 0;
            m_tick       = 0;
            m_out_clk    = 0;
            m_tick_count = 0;
        end else if (!run) begin
            m_level     = (int'(speed_sel) > MAX_LEVEL) ? MAX_LEVEL : int'(speed_sel);
            m_remaining = period(m_level);
            m_acc       = 0;
            m_tick      = 0;
        end else if (pause) begin
            m_tick = 0;
        end else begin
            m_remaining--;
            if (m_remaining == 0) begin
                m_tick       = 1;
                m_out_clk    = 1 - m_out_clk;
                m_tick_count = (m_tick_count + 1) % (1 << TCNT_W);
                if (accel_en) begin
                    if (m_acc == ACCEL_TICKS - 1) begin
                        m_acc   = 0;
                        m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
                    end else begin
                        m_acc++;
                    end
                end
                m_remaining = period(m_level);
            end else begin
                m_tick = 0;
            end
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_tick", int'(tick), m_tick);
            checkOutput("model_out_clk", int'(out_clk), m_out_clk);
            checkOutput("model_level", int'(level), m_level);
            checkOutput("model_tick_count", int'(tick_count), m_tick_count);
        end
    end

    initial begin
        int w;
        int saved_tc;
        int exp_int[18];
        int exp_lvl[18];
        total_checks = 0;
        bad_checks   = 0;
        check_en     = 1'b0;

        exp_int = '{10,10,8,8,6,6,4,4,3,3,3,3,3,3,3,3,3,3};
        exp_lvl = '{0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,7,7,7};

        // 1: reset held with run high, then release into idle
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5);
        @(negedge clk);
        check_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_tick", int'(tick), 0);
            checkOutput("rst_out_clk", int'(out_clk), 0);
            checkOutput("rst_level", int'(level), 0);
            checkOutput("rst_tick_count", int'(tick_count), 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5);
        @(negedge clk);
        checkOutput("idle_level", int'(level), 5);
        checkOutput("idle_tick", int'(tick), 0);

        // 2: level 0, period 10
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        waitTick(30, w);
        checkOutput("first_interval", w, 10);
        checkOutput("tc_1", int'(tick_count), 1);
        checkOutput("oclk_1", int'(out_clk), 1);
        waitTick(30, w);
        checkOutput("interval_2", w, 10);
        checkOutput("tc_2", int'(tick_count), 2);
        checkOutput("oclk_2", int'(out_clk), 0);
        waitTick(30, w);
        checkOutput("interval_3", w, 10);
        checkOutput("tc_3", int'(tick_count), 3);

        // 3: other levels, clamp, and speed_sel ignored while running
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
        waitTick(30, w);
        checkOutput("lvl3_first", w, 4);
        checkOutput("lvl3_level", int'(level), 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        waitTick(30, w);
        checkOutput("lvl3_sel_ignored", w, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4);
        waitTick(30, w);
        checkOutput("lvl4_clamped", w, 3);
        waitTick(30, w);
        checkOutput("lvl4_steady", w, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7);
        waitTick(30, w);
        checkOutput("lvl7_clamped", w, 3);
        checkOutput("lvl7_level", int'(level), 7);

        // 4: pause for 5 cycles with 4 cycles left
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        waitTick(30, w);
        repeat (6) @(negedge clk);
        saved_tc = int'(tick_count);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("pause_tick", int'(tick), 0);
            checkOutput("pause_tc_frozen", int'(tick_count), saved_tc);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        waitTick(30, w);
        checkOutput("pause_total_delay", (w < 0) ? -1 : w + 5, 9);

        // 5: automatic acceleration from level 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 0; k < 18; k++) begin
            waitTick(30, w);
            checkOutput($sformatf("accel_interval_%0d", k + 1), w, exp_int[k]);
            checkOutput($sformatf("accel_level_%0d", k + 1), int'(level), exp_lvl[k]);
        end

        // 6a: run dropped mid-interval restarts a full interval
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        waitTick(30, w);
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        waitTick(30, w);
        checkOutput("restart_interval", w, 10);

        // 6b: tick_count wrap at the shortest period
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7);
        for (int i = 0; i < 300 && int'(tick_count) != 255; i++)
            waitTick(10, w);
        checkOutput("tc_255", int'(tick_count), 255);
        waitTick(10, w);
        checkOutput("tc_wrap", int'(tick_count), 0);

        // 6c: reset pulse mid-interval
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7);
        @(negedge clk);
        checkOutput("midrst_tick", int'(tick), 0);
        checkOutput("midrst_out_clk", int'(out_clk), 0);
        checkOutput("midrst_level", int'(level), 0);
        checkOutput("midrst_tick_count", int'(tick_count), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
